axi4_lite_slave_regs: RTL and testbench

AXI4-Lite slave register bank that terminates the transactions issued by the team's AXI4-Lite master. It sits directly downstream of that master on the same 32-bit AXI4-Lite link and holds NUM_REGS 32-bit read/write control registers. Register contents are exposed to user logic, with a one-cycle write-notify pulse. The write and read channels operate independently; out-of-range accesses complete with SLVERR.

---
 rtl/axi4_lite_slave_regs.sv | 169 ++++++++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register bank: NUM_REGS 32-bit R/W registers with byte strobes,
// independent write/read channels, SLVERR on out-of-range index, write-notify pulse.
module axi4_lite_slave_regs #(
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [31:0]              S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]   reg_q,
  output logic                     wr_pulse,
  output logic [7:0]               wr_index
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_VALID} rstate_e;

  logic        aw_full_q, w_full_q;
  logic [7:0]  aw_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        wr_pulse_q;
  logic [7:0]  wr_index_q;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  rstate_e     rstate_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        aw_hs, w_hs, ar_hs, commit;
  logic [7:0]  wr_idx, ar_idx;
  logic [31:0] wr_data, rd_word;
  logic [3:0]  wr_strb;
  logic        wr_in_range, ar_in_range;

  // Address bits outside [9:2] are don't-care for decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR[31:10], S_AXI_AWADDR[1:0],
                              S_AXI_ARADDR[31:10], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = !rst && !aw_full_q && !bvalid_q;
  assign S_AXI_WREADY  = !rst && !w_full_q  && !bvalid_q;
  assign S_AXI_ARREADY = !rst && (rstate_q == R_IDLE);
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (rstate_q == R_VALID);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse      = wr_pulse_q;
  assign wr_index      = wr_index_q;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_q[32*i +: 32] = regs_q[i];
    end
  end

  // Commit uses whichever of AW/W is arriving this cycle, else the latched copy.
  always_comb begin
    aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
    w_hs        = S_AXI_WVALID  && S_AXI_WREADY;
    ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
    commit      = (aw_full_q || aw_hs) && (w_full_q || w_hs);
    wr_idx      = aw_hs ? S_AXI_AWADDR[9:2] : aw_idx_q;
    wr_data     = w_hs  ? S_AXI_WDATA       : wdata_q;
    wr_strb     = w_hs  ? S_AXI_WSTRB       : wstrb_q;
    wr_in_range = {1'b0, wr_idx} < 9'(NUM_REGS);
    ar_idx      = S_AXI_ARADDR[9:2];
    ar_in_range = {1'b0, ar_idx} < 9'(NUM_REGS);
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && (wr_idx == 8'(i))) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (wr_strb[b]) regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read mux sees regs_q, so a same-edge write is not visible to this read.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == 8'(i)) rd_word = regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= 1'b0;
      wr_index_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      wr_pulse_q <= commit && wr_in_range;
      if (commit && wr_in_range) wr_index_q <= wr_idx;
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_full_q <= 1'b1;
          aw_idx_q  <= S_AXI_AWADDR[9:2];
        end
        if (w_hs) begin
          w_full_q <= 1'b1;
          wdata_q  <= S_AXI_WDATA;
          wstrb_q  <= S_AXI_WSTRB;
        end
        if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q  <= ar_in_range ? rd_word : '0;
            rresp_q  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rstate_q <= R_VALID;
          end
        end
        R_VALID: begin
          if (S_AXI_RREADY) rstate_q <= R_IDLE;
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs: directed scenarios plus randomized
// traffic compared against an array-based register model.
module tb_axi4_lite_slave_regs;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
  logic S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [3:0] S_AXI_WSTRB;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic S_AXI_RVALID, S_AXI_RREADY;
  logic [32*N-1:0] reg_q;
  logic wr_pulse;
  logic [7:0] wr_index;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [N];

  always #5 clk = ~clk;

  axi4_lite_slave_regs #(.NUM_REGS(N)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_q(reg_q), .wr_pulse(wr_pulse), .wr_index(wr_index)
  );

  function automatic logic [32*N-1:0] model_vec();
    logic [32*N-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  // Drivers only; callers compare results. Entered and left just after a rising edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_del, input int w_del, output logic [1:0] resp,
                          output logic pulse, output logic [7:0] pidx, output bit to);
    bit awd, wd;
    int c;
    logic awr, wr;
    awd = 0; wd = 0; c = 0; to = 0; resp = 2'b11; pulse = 0; pidx = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(awd && wd)) begin
      if (!awd && c >= aw_del) S_AXI_AWVALID = 1;
      if (!wd && c >= w_del) S_AXI_WVALID = 1;
      awr = S_AXI_AWREADY; wr = S_AXI_WREADY;
      @(posedge clk); #1;
      if (S_AXI_AWVALID && awr) begin awd = 1; S_AXI_AWVALID = 0; end
      if (S_AXI_WVALID && wr) begin wd = 1; S_AXI_WVALID = 0; end
      c++;
      if (c > 30) begin to = 1; S_AXI_AWVALID = 0; S_AXI_WVALID = 0; return; end
    end
    c = 0;
    while (!S_AXI_BVALID && c < 10) begin @(posedge clk); #1; c++; end
    if (!S_AXI_BVALID) begin to = 1; return; end
    resp = S_AXI_BRESP; pulse = wr_pulse; pidx = wr_index;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output bit to);
    int c;
    logic arr;
    bit done;
    c = 0; to = 0; done = 0; data = 'x; resp = 2'b11;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1;
    while (!done) begin
      arr = S_AXI_ARREADY;
      @(posedge clk); #1;
      if (arr) begin done = 1; S_AXI_ARVALID = 0; end
      c++;
      if (c > 20) begin to = 1; S_AXI_ARVALID = 0; return; end
    end
    c = 0;
    while (!S_AXI_RVALID && c < 10) begin @(posedge clk); #1; c++; end
    if (!S_AXI_RVALID) begin to = 1; return; end
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
      errors++; $display("FAIL reset_ready_low: got %b want 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    @(posedge clk); #1;
    rst = 0; #1;
    checks++;
    if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, wr_pulse, wr_index} !== 15'd0 ||
        S_AXI_RDATA !== 32'h0 || reg_q !== '0) begin
      errors++; $display("FAIL reset_state: bv=%b rv=%b br=%b rr=%b rd=%h wp=%b wi=%0d", S_AXI_BVALID,
                         S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, wr_pulse, wr_index);
    end
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      errors++; $display("FAIL reset_ready_high: got %b want 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [1:0] r; bit to;
    S_AXI_AWADDR = 32'h08; S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    model[2] = 32'hDEADBEEF;
    checks++;
    if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) begin
      errors++; $display("FAIL basic_b: bvalid=%b bresp=%b want 1/00", S_AXI_BVALID, S_AXI_BRESP);
    end
    checks++;
    if (wr_pulse !== 1'b1 || wr_index !== 8'd2) begin
      errors++; $display("FAIL basic_pulse: pulse=%b idx=%0d want 1/2", wr_pulse, wr_index);
    end
    checks++;
    if (reg_q[95:64] !== 32'hDEADBEEF || reg_q !== model_vec()) begin
      errors++; $display("FAIL basic_reg: got %h want %h", reg_q, model_vec());
    end
    @(posedge clk); #1;
    checks++;
    if (S_AXI_BVALID !== 1'b0 || wr_pulse !== 1'b0) begin
      errors++; $display("FAIL basic_one_shot: bvalid=%b pulse=%b want 0/0", S_AXI_BVALID, wr_pulse);
    end
    do_read(32'h08, d, r, to);
    checks++;
    if (to || d !== 32'hDEADBEEF || r !== 2'b00) begin
      errors++; $display("FAIL basic_read: to=%0d data=%h resp=%b want DEADBEEF/00", to, d, r);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r; logic p; logic [7:0] pi; bit to;
    do_write(32'h04, 32'hFFFFFFFF, 4'hF, 0, 0, r, p, pi, to);
    model[1] = 32'hFFFFFFFF;
    S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'b0101; S_AXI_WVALID = 1;
    @(posedge clk); #1;
    S_AXI_WVALID = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (S_AXI_WREADY !== 1'b0 || S_AXI_BVALID !== 1'b0) begin
        errors++; $display("FAIL wfirst_hold[%0d]: wready=%b bvalid=%b want 0/0", k, S_AXI_WREADY, S_AXI_BVALID);
      end
      if (k < 2) begin @(posedge clk); #1; end
    end
    S_AXI_AWADDR = 32'h04; S_AXI_AWVALID = 1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 0;
    model[1] = apply_strb(model[1], 32'h12345678, 4'b0101);
    checks++;
    if (S_AXI_BVALID !== 1'b1 || reg_q[63:32] !== 32'hFF34FF78 || reg_q !== model_vec() || wr_index !== 8'd1) begin
      errors++; $display("FAIL wfirst_commit: bvalid=%b reg1=%h idx=%0d want 1/FF34FF78/1",
                         S_AXI_BVALID, reg_q[63:32], wr_index);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic p; logic [7:0] pi; bit to; logic [31:0] d;
    do_write(32'h20, 32'h55AA55AA, 4'hF, 1, 0, r, p, pi, to);
    checks++;
    if (to || r !== 2'b10 || p !== 1'b0 || reg_q !== model_vec()) begin
      errors++; $display("FAIL oor_write: to=%0d bresp=%b pulse=%b want 10/0 regs_changed=%0d",
                         to, r, p, reg_q !== model_vec());
    end
    do_read(32'h20, d, r, to);
    checks++;
    if (to || r !== 2'b10 || d !== 32'h0) begin
      errors++; $display("FAIL oor_read: to=%0d rresp=%b rdata=%h want 10/0", to, r, d);
    end
  endtask

  task automatic test_bready_stall();
    logic [31:0] d1, d2;
    d1 = $urandom(); d2 = $urandom();
    S_AXI_BREADY = 0;
    S_AXI_AWADDR = 32'h14; S_AXI_WDATA = d1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    @(posedge clk); #1;
    model[5] = d1;
    S_AXI_AWADDR = 32'h18; S_AXI_WDATA = d2;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00 || S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) begin
        errors++; $display("FAIL stall[%0d]: bv=%b br=%b awr=%b wr=%b want 1/00/0/0", k,
                           S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY);
      end
      @(posedge clk); #1;
    end
    S_AXI_BREADY = 1;
    @(posedge clk); #1;
    checks++;
    if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1 || reg_q !== model_vec()) begin
      errors++; $display("FAIL stall_release: bv=%b awr=%b want 0/1 regs_ok=%0d",
                         S_AXI_BVALID, S_AXI_AWREADY, reg_q === model_vec());
    end
    @(posedge clk); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    model[6] = d2;
    checks++;
    if (S_AXI_BVALID !== 1'b1 || reg_q !== model_vec()) begin
      errors++; $display("FAIL stall_second: bv=%b reg6=%h want 1/%h", S_AXI_BVALID, reg_q[223:192], d2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rw_collision();
    logic [1:0] r; logic p; logic [7:0] pi; bit to; logic [31:0] d;
    do_write(32'h04, 32'h00000001, 4'hF, 0, 0, r, p, pi, to);
    model[1] = 32'h00000001;
    S_AXI_AWADDR = 32'h04; S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 32'h04;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    checks++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== model[1]) begin
      errors++; $display("FAIL collide_old: rvalid=%b rdata=%h want 1/%h", S_AXI_RVALID, S_AXI_RDATA, model[1]);
    end
    model[1] = 32'hA5A5A5A5;
    checks++;
    if (S_AXI_BVALID !== 1'b1 || reg_q !== model_vec()) begin
      errors++; $display("FAIL collide_write: bvalid=%b reg1=%h want 1/A5A5A5A5", S_AXI_BVALID, reg_q[63:32]);
    end
    @(posedge clk); #1;
    do_read(32'h04, d, r, to);
    checks++;
    if (to || d !== 32'hA5A5A5A5 || r !== 2'b00) begin
      errors++; $display("FAIL collide_new: to=%0d rdata=%h want A5A5A5A5", to, d);
    end
  endtask

  task automatic test_reset_mid();
    S_AXI_RREADY = 0;
    S_AXI_ARADDR = 32'h08; S_AXI_ARVALID = 1;
    S_AXI_AWADDR = 32'h10; S_AXI_AWVALID = 1;
    @(posedge clk); #1;
    S_AXI_ARVALID = 0; S_AXI_AWVALID = 0;
    checks++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_AWREADY !== 1'b0) begin
      errors++; $display("FAIL rstmid_setup: rvalid=%b awready=%b want 1/0", S_AXI_RVALID, S_AXI_AWREADY);
    end
    rst = 1; #1;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
      errors++; $display("FAIL rstmid_ready: got %b want 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    @(posedge clk); #1;
    rst = 0; S_AXI_RREADY = 1;
    for (int i = 0; i < N; i++) model[i] = '0;
    checks++;
    if (S_AXI_RVALID !== 1'b0 || S_AXI_BVALID !== 1'b0 || reg_q !== '0 || wr_pulse !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear: rvalid=%b bvalid=%b pulse=%b regs_zero=%0d",
                         S_AXI_RVALID, S_AXI_BVALID, wr_pulse, reg_q === '0);
    end
    S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
    @(posedge clk); #1;
    S_AXI_WVALID = 0;
    checks++;
    if (S_AXI_BVALID !== 1'b0 || reg_q !== '0) begin
      errors++; $display("FAIL rstmid_aw_discarded: bvalid=%b want 0", S_AXI_BVALID);
    end
    S_AXI_AWADDR = 32'h0C; S_AXI_AWVALID = 1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 0;
    model[3] = 32'hCAFEF00D;
    checks++;
    if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00 || reg_q !== model_vec() || wr_index !== 8'd3) begin
      errors++; $display("FAIL rstmid_fresh: bvalid=%b bresp=%b reg3=%h idx=%0d want 1/00/CAFEF00D/3",
                         S_AXI_BVALID, S_AXI_BRESP, reg_q[127:96], wr_index);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [1:0] r; logic p; logic [7:0] pi; bit to;
    logic [31:0] d, rnd, addr;
    logic [7:0] idx;
    logic [3:0] strb;
    for (int it = 0; it < 60; it++) begin
      rnd = $urandom();
      idx = 8'($urandom_range(11, 0));
      addr = {rnd[31:10], idx, rnd[1:0]};
      if ($urandom_range(1, 0) == 1) begin
        d = $urandom();
        strb = 4'($urandom_range(15, 0));
        do_write(addr, d, strb, $urandom_range(2, 0), $urandom_range(2, 0), r, p, pi, to);
        if (idx < N) model[idx] = apply_strb(model[idx], d, strb);
        checks++;
        if (to || r !== ((idx < N) ? 2'b00 : 2'b10) || p !== (idx < N) ||
            (idx < N && pi !== idx) || reg_q !== model_vec()) begin
          errors++; $display("FAIL rand_write[%0d]: idx=%0d to=%0d bresp=%b pulse=%b pidx=%0d regs_ok=%0d",
                             it, idx, to, r, p, pi, reg_q === model_vec());
        end
      end else begin
        do_read(addr, d, r, to);
        checks++;
        if (to || r !== ((idx < N) ? 2'b00 : 2'b10) || d !== ((idx < N) ? model[idx] : 32'h0)) begin
          errors++; $display("FAIL rand_read[%0d]: idx=%0d to=%0d rresp=%b rdata=%h want %h",
                             it, idx, to, r, d, (idx < N) ? model[idx] : 32'h0);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0;
    S_AXI_BREADY = 1; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_w_before_aw();
    test_out_of_range();
    test_bready_stall();
    test_rw_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
